circuito_jogo_sequencia: RTL

- Parametrised successor of the fixed 4-key single-pass memory game.
- Plays a "Genius"-style growing-sequence game. Round r requires the player to repeat sequence positions 0..r, and each round adds one step.
- Generalised in key count, sequence depth and timeout. Adds per-move timeout, selectable game length and an optional LED playback.
- Contains its own datapath and control FSM. It sits under the board top, which adds the 7-segment decoders.

---
 rtl/circuito_jogo_sequencia_if.sv | 39 +++
 rtl/circuito_jogo_sequencia.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/circuito_jogo_sequencia_if.sv
// Game I/O bundle for circuito_jogo_sequencia.
// The master side (board or bench) drives the player inputs.
// The slave side (the game) drives the result and debug outputs.
interface circuito_jogo_sequencia_if #(
    parameter int N_CHAVES = 4,
    parameter int DEPTH    = 16
);
    localparam int AW = $clog2(DEPTH);

    logic                iniciar;
    logic                nivel;
    logic [N_CHAVES-1:0] chaves;
    logic                acertou;
    logic                errou;
    logic                timeout;
    logic                pronto;
    logic [N_CHAVES-1:0] leds;
    logic [3:0]          db_estado;
    logic [AW-1:0]       db_rodada;
    logic [AW-1:0]       db_endereco;
    logic [N_CHAVES-1:0] db_memoria;
    logic [N_CHAVES-1:0] db_jogada;
    logic                db_meio_tempo;
    logic                db_nivel;

    modport master (
        output iniciar, nivel, chaves,
        input  acertou, errou, timeout, pronto, leds,
        input  db_estado, db_rodada, db_endereco, db_memoria,
        input  db_jogada, db_meio_tempo, db_nivel
    );

    modport slave (
        input  iniciar, nivel, chaves,
        output acertou, errou, timeout, pronto, leds,
        output db_estado, db_rodada, db_endereco, db_memoria,
        output db_jogada, db_meio_tempo, db_nivel
    );
endinterface

// File: rtl/circuito_jogo_sequencia.sv
// Growing-sequence memory game: round r asks the player to repeat
// sequence positions 0..r, with a per-move timeout and two game lengths.
// Optional LED playback of the sequence at the start of each round is
// built in when CIRCUITO_JOGO_SEQUENCIA_MOSTRA_EN is defined.
module circuito_jogo_sequencia #(
    parameter int N_CHAVES = 4,
    parameter int DEPTH    = 16,
    parameter int TIMEOUT  = 5000,
    parameter int SEED     = 0,
    parameter int SHOW     = 1000
) (
    input logic                      clock,
    input logic                      reset,
    circuito_jogo_sequencia_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [TW-1:0] TEMPO_MAX    = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TEMPO_MEIO   = TW'(TIMEOUT / 2);
    localparam logic [AW-1:0] ULTIMA_CURTA = AW'(DEPTH / 2 - 1);
    localparam logic [AW-1:0] ULTIMA_LONGA = AW'(DEPTH - 1);

    // Reject parameter sets the counters cannot represent.
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_invalid
        $error("DEPTH must be a power of 2 and at least 4");
    end
    if (SHOW < 1) begin : g_show_invalid
        $error("SHOW must be at least 1");
    end

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        PREPARA        = 4'd1,
        INICIO_RODADA  = 4'd2,
        ESPERA         = 4'd3,
        REGISTRA       = 4'd4,
        COMPARA        = 4'd5,
        PROXIMA        = 4'd6,
        ULTIMA_CHECK   = 4'd7,
        PROXIMA_RODADA = 4'd8,
        MOSTRA         = 4'd9,
        FIM_ACERTO     = 4'd10,
        FIM_ERRO       = 4'd14,
        FIM_TIMEOUT    = 4'd15
    } estado_t;

    // Sequence ROM: position i lights key (3*i + SEED) mod N_CHAVES.
    function automatic logic [N_CHAVES-1:0] rom_word(input logic [AW-1:0] addr);
        int idx;
        idx      = (3 * int'(addr) + SEED) % N_CHAVES;
        rom_word = N_CHAVES'(1) << idx;
    endfunction

    estado_t             estado;
    logic [N_CHAVES-1:0] chaves_q;
    logic [N_CHAVES-1:0] jogada;
    logic [AW-1:0]       endereco;
    logic [AW-1:0]       rodada;
    logic [TW-1:0]       tempo;
    logic                nivel_reg;
    logic                pronto_r;
    logic                acertou_r;
    logic                errou_r;
    logic                timeout_r;
    logic [N_CHAVES-1:0] memoria;
    logic [AW-1:0]       ultima;
    logic                jogada_feita;

`ifdef CIRCUITO_JOGO_SEQUENCIA_MOSTRA_EN
    localparam int SW = (SHOW > 1) ? $clog2(SHOW) : 1;
    localparam logic [SW-1:0] MOSTRA_MAX = SW'(SHOW - 1);

    logic [SW-1:0] mostra_cnt;
    logic          mostra_apagado;
`endif

    assign memoria = rom_word(endereco);
    assign ultima  = nivel_reg ? ULTIMA_LONGA : ULTIMA_CURTA;

    // A press is the first cycle a key appears after all keys were released,
    // so a held key yields exactly one event.
    assign jogada_feita = (bus.chaves != '0) && (chaves_q == '0);

    // Previous-cycle key snapshot for press edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            chaves_q <= '0;
        end else begin
            chaves_q <= bus.chaves;
        end
    end

    // Game controller with its datapath registers and registered result flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado    <= INICIAL;
            jogada    <= '0;
            endereco  <= '0;
            rodada    <= '0;
            tempo     <= '0;
            nivel_reg <= 1'b0;
            pronto_r  <= 1'b0;
            acertou_r <= 1'b0;
            errou_r   <= 1'b0;
            timeout_r <= 1'b0;
`ifdef CIRCUITO_JOGO_SEQUENCIA_MOSTRA_EN
            mostra_cnt     <= '0;
            mostra_apagado <= 1'b0;
`endif
        end else begin
            case (estado)
                INICIAL: begin
                    if (bus.iniciar) estado <= PREPARA;
                end
                PREPARA: begin
                    rodada    <= '0;
                    endereco  <= '0;
                    jogada    <= '0;
                    tempo     <= '0;
                    nivel_reg <= bus.nivel;
                    estado    <= INICIO_RODADA;
                end
                INICIO_RODADA: begin
                    endereco <= '0;
                    tempo    <= '0;
`ifdef CIRCUITO_JOGO_SEQUENCIA_MOSTRA_EN
                    mostra_cnt     <= '0;
                    mostra_apagado <= 1'b0;
                    estado         <= MOSTRA;
`else
                    estado   <= ESPERA;
`endif
                end
`ifdef CIRCUITO_JOGO_SEQUENCIA_MOSTRA_EN
                MOSTRA: begin
                    // Each step is lit for SHOW cycles, then dark for SHOW cycles.
                    if (mostra_cnt == MOSTRA_MAX) begin
                        mostra_cnt <= '0;
                        if (!mostra_apagado) begin
                            mostra_apagado <= 1'b1;
                        end else begin
                            mostra_apagado <= 1'b0;
                            if (endereco == rodada) begin
                                endereco <= '0;
                                tempo    <= '0;
                                estado   <= ESPERA;
                            end else begin
                                endereco <= endereco + AW'(1);
                            end
                        end
                    end else begin
                        mostra_cnt <= mostra_cnt + SW'(1);
                    end
                end
`endif
                ESPERA: begin
                    // Saturate at the last allowed cycle so the counter never wraps.
                    if (tempo != TEMPO_MAX) tempo <= tempo + TW'(1);
                    if (jogada_feita) begin
                        estado <= REGISTRA;
                    end else if (tempo == TEMPO_MAX) begin
                        estado    <= FIM_TIMEOUT;
                        pronto_r  <= 1'b1;
                        errou_r   <= 1'b1;
                        timeout_r <= 1'b1;
                    end
                end
                REGISTRA: begin
                    jogada <= bus.chaves;
                    tempo  <= '0;
                    estado <= COMPARA;
                end
                COMPARA: begin
                    // Multi-key moves never equal a one-hot ROM word.
                    if (jogada != memoria) begin
                        estado   <= FIM_ERRO;
                        pronto_r <= 1'b1;
                        errou_r  <= 1'b1;
                    end else if (endereco == rodada) begin
                        estado <= ULTIMA_CHECK;
                    end else begin
                        estado <= PROXIMA;
                    end
                end
                PROXIMA: begin
                    endereco <= endereco + AW'(1);
                    estado   <= ESPERA;
                end
                ULTIMA_CHECK: begin
                    if (rodada == ultima) begin
                        estado    <= FIM_ACERTO;
                        pronto_r  <= 1'b1;
                        acertou_r <= 1'b1;
                    end else begin
                        estado <= PROXIMA_RODADA;
                    end
                end
                PROXIMA_RODADA: begin
                    rodada <= rodada + AW'(1);
                    estado <= INICIO_RODADA;
                end
                FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                    // Flags drop together with leaving the final state.
                    if (bus.iniciar) begin
                        estado    <= PREPARA;
                        pronto_r  <= 1'b0;
                        acertou_r <= 1'b0;
                        errou_r   <= 1'b0;
                        timeout_r <= 1'b0;
                    end
                end
                default: begin
                    estado <= INICIAL;
                end
            endcase
        end
    end

`ifdef CIRCUITO_JOGO_SEQUENCIA_MOSTRA_EN
    assign bus.leds = (estado == MOSTRA) ? (mostra_apagado ? '0 : memoria) : jogada;
`else
    assign bus.leds = jogada;
`endif

    assign bus.pronto        = pronto_r;
    assign bus.acertou       = acertou_r;
    assign bus.errou         = errou_r;
    assign bus.timeout       = timeout_r;
    assign bus.db_estado     = estado;
    assign bus.db_rodada     = rodada;
    assign bus.db_endereco   = endereco;
    assign bus.db_memoria    = memoria;
    assign bus.db_jogada     = jogada;
    assign bus.db_meio_tempo = (tempo >= TEMPO_MEIO);
    assign bus.db_nivel      = nivel_reg;
endmodule
